alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: ALU_WAIT, 2, cycles ALU ports held stable before result capture (legal range 1-15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr  in  16  [15:11] alu_code, [10:8] rd, [7:5] rs, [4:2] rt, [1:0] ignored.
REQ-006 instr_ready  out  1  block can accept an instruction.
REQ-007 ld_en / ld_addr / ld_data  in  1/3/16  register-file load port.
REQ-008 rd_addr  in  3  debug read address; rd_data  out  16  combinational read of regfile[rd_addr].
REQ-009 alu_a, alu_b  out  16  registered ALU operands; alu_code  out  5  registered ALU operation.
REQ-010 alu_c  in  16  ALU result; alu_ovf  in  1  ALU signed overflow.
REQ-011 result  out  16  last written-back value; done  out  1  one-cycle completion pulse.
REQ-012 illegal  out  1  one-cycle pulse for rejected opcode; ovf_flag  out  1  sticky overflow; ovf_clr  in  1  clears ovf_flag.

Function
REQ-013 Register file SHALL be 8 x 16 bits; register 0 SHALL read 0 and ignore all writes.
REQ-014 FSM states SHALL be IDLE, ISSUE, WAIT; instr_ready SHALL equal (state == IDLE).
REQ-015 IDLE: instr_valid & instr_ready at an edge SHALL latch instr and move to ISSUE.
REQ-016 Legal codes SHALL be 00000-00101, 01000-01010, 01100, 10000-10011, 11000-11101; all others illegal.
REQ-017 ISSUE, illegal code: SHALL pulse illegal for one cycle, leave ALU ports and regfile unchanged, return to IDLE.
REQ-018 ISSUE, legal code: SHALL load alu_a=reg[rs], alu_b=reg[rt], alu_code=code, counter=ALU_WAIT-1, enter WAIT.
REQ-019 WAIT: counter nonzero SHALL decrement; counter zero SHALL capture alu_c into result and reg[rd], pulse done, return to IDLE.
REQ-020 Latency: done SHALL be high in the cycle following edge accept+1+ALU_WAIT (default: 3 edges after accept).
REQ-021 ALU ports SHALL hold their values from ISSUE exit until the next legal ISSUE; they SHALL NOT change in IDLE.
REQ-022 ovf_flag SHALL set at capture when alu_ovf=1 and code in {00000,00010,00100,00101}; other codes SHALL not set it.
REQ-023 ovf_clr SHALL clear ovf_flag at the edge; simultaneous set and clear SHALL leave ovf_flag=1.
REQ-024 ld_en SHALL write only when state==IDLE and not accepting; ld_en otherwise SHALL be ignored.
REQ-025 Back-to-back: an instruction SHALL be acceptable in the done cycle; its ISSUE SHALL read the just-written value.
REQ-026 rd=0 with legal code SHALL complete normally (done, result updated) with regfile unchanged.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, instr_ready=1, alu_a=alu_b=0, alu_code=0, result=0, done=0, illegal=0, ovf_flag=0, counter=0, all registers 0.
REQ-028 Reset during ISSUE/WAIT SHALL abandon the in-flight instruction with no write-back and no done pulse.

Verification
REQ-029 ld r1=0x0005, r2=0x0003; instr code 00000 rd=3 rs=1 rt=2 -> alu_a=5, alu_b=3, done 3 edges after accept, r3=result=0x0008.
REQ-030 r1=0x7FFF, r2=0x0001, code 00000 rd=4 -> result 0x8000 with alu_ovf=1, ovf_flag=1; ovf_clr pulse -> ovf_flag=0.
REQ-031 code 00110 offered -> illegal pulses one cycle after accept, no done, ALU ports and regfile unchanged, instr_ready=1 next cycle.
REQ-032 Back-to-back: 00000 rd=3 (r1+r2), then 01010 rd=5 rs=3 rt=1 accepted in done cycle -> alu_a=0x0008, r5=0x000D.
REQ-033 rst_n low during WAIT of code 00001 rd=6 -> no done, r6=0, all outputs at reset values, instr_ready=1 asynchronously.
REQ-034 ALU_WAIT=1 and ALU_WAIT=4 builds -> done at accept+2 and accept+5 edges respectively; ld_en asserted in WAIT has no effect.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: holds an 8x16 register file and issues one instruction at a time to an external ALU.
// Accept-to-done latency is 1+ALU_WAIT edges. instr_ready stays low from accept until write-back, which stalls new instructions.
module alu_issue_ctrl #(
    parameter int ALU_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic [2:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_code,
    input  logic [15:0] alu_c,
    input  logic        alu_ovf,
    output logic [15:0] result,
    output logic        done,
    output logic        illegal,
    output logic        ovf_flag,
    input  logic        ovf_clr
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_WAIT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [13:0] r_instr;
    logic [15:0] r_regs [8];
    logic [3:0]  r_cnt;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [4:0]  r_alu_code;
    logic [15:0] r_result;
    logic        r_done;
    logic        r_illegal;
    logic        r_ovf_flag;

    logic [4:0]  w_code;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs;
    logic [2:0]  w_rt;
    logic        w_legal;
    logic        w_ovf_code;
    logic        w_accept;
    logic        w_issue_ok;
    logic        w_issue_bad;
    logic        w_capture;
    logic        w_ld_wr;
    logic        w_unused;

    // Low two instruction bits carry no meaning and are never stored.
    assign w_unused = &{1'b0, instr[1:0]};

    assign w_code = r_instr[13:9];
    assign w_rd   = r_instr[8:6];
    assign w_rs   = r_instr[5:3];
    assign w_rt   = r_instr[2:0];

    assign w_legal = (w_code <= 5'd5)
                  || ((w_code >= 5'd8)  && (w_code <= 5'd10))
                  || (w_code == 5'd12)
                  || ((w_code >= 5'd16) && (w_code <= 5'd19))
                  || ((w_code >= 5'd24) && (w_code <= 5'd29));

    assign w_ovf_code = (w_code == 5'd0) || (w_code == 5'd2)
                     || (w_code == 5'd4) || (w_code == 5'd5);

    // Loads lose to an instruction accepted in the same cycle.
    assign w_ld_wr = (r_state == IDLE) && ld_en && !instr_valid && (ld_addr != 3'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_issue_ok  = 1'b0;
        w_issue_bad = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (instr_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (w_legal) begin
                    w_issue_ok  = 1'b1;
                    w_state_nxt = WAIT;
                end else begin
                    w_issue_bad = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_instr    <= '0;
            r_cnt      <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_code <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_ovf_flag <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_capture;
            r_illegal <= w_issue_bad;

            if (w_accept) begin
                r_instr <= instr[15:2];
            end

            if (w_issue_ok) begin
                r_alu_a    <= r_regs[w_rs];
                r_alu_b    <= r_regs[w_rt];
                r_alu_code <= w_code;
                r_cnt      <= CNT_INIT;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                r_result <= alu_c;
                if (w_rd != 3'd0) begin
                    r_regs[w_rd] <= alu_c;
                end
            end

            if (w_ld_wr) begin
                r_regs[ld_addr] <= ld_data;
            end

            // A set at write-back wins over a simultaneous clear.
            if (w_capture && alu_ovf && w_ovf_code) begin
                r_ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_flag <= 1'b0;
            end
        end
    end

    assign instr_ready = (r_state == IDLE);
    assign rd_data     = (rd_addr == 3'd0) ? 16'h0000 : r_regs[rd_addr];
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_code    = r_alu_code;
    assign result      = r_result;
    assign done        = r_done;
    assign illegal     = r_illegal;
    assign ovf_flag    = r_ovf_flag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: three instances (ALU_WAIT 2/1/4) sharing stimulus, each driven by a small reference ALU.
module tb_alu_issue_ctrl;
    logic        clk;
    logic        rst_n;
    logic [15:0] instr;
    logic        v_m, v_1, v_4;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  rd_addr;
    logic        ovf_clr;
    logic        force_ovf;

    logic        instr_ready_m, done_m, illegal_m, ovf_flag_m, alu_ovf_m;
    logic [15:0] rd_data_m, alu_a_m, alu_b_m, alu_c_m, result_m;
    logic [4:0]  alu_code_m;
    logic        instr_ready_1, done_1, illegal_1, ovf_flag_1, alu_ovf_1;
    logic [15:0] rd_data_1, alu_a_1, alu_b_1, alu_c_1, result_1;
    logic [4:0]  alu_code_1;
    logic        instr_ready_4, done_4, illegal_4, ovf_flag_4, alu_ovf_4;
    logic [15:0] rd_data_4, alu_a_4, alu_b_4, alu_c_4, result_4;
    logic [4:0]  alu_code_4;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [4:0]  code;
        logic [2:0]  rd, rs, rt;
        logic [15:0] ld_s, ld_t;
        logic [15:0] exp_a, exp_b, exp_res, exp_rd;
    } vec_t;

    vec_t       vecs [8];
    logic [4:0] bad_codes [7];

    // Reference ALU: add, sub, or, and xor for every other code.
    function automatic logic [16:0] alu_model(input logic [4:0] c, input logic [15:0] a, input logic [15:0] b,
                                              input logic fo);
        logic [15:0] s;
        logic        o;
        case (c)
            5'd0: begin s = a + b; o = (a[15] == b[15]) && (s[15] != a[15]); end
            5'd1: begin s = a - b; o = (a[15] != b[15]) && (s[15] != a[15]); end
            5'd10: begin s = a | b; o = 1'b0; end
            default: begin s = a ^ b; o = 1'b0; end
        endcase
        return {o | fo, s};
    endfunction

    assign {alu_ovf_m, alu_c_m} = alu_model(alu_code_m, alu_a_m, alu_b_m, force_ovf);
    assign {alu_ovf_1, alu_c_1} = alu_model(alu_code_1, alu_a_1, alu_b_1, force_ovf);
    assign {alu_ovf_4, alu_c_4} = alu_model(alu_code_4, alu_a_4, alu_b_4, force_ovf);

    alu_issue_ctrl #(.ALU_WAIT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(v_m), .instr(instr), .instr_ready(instr_ready_m),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data_m),
        .alu_a(alu_a_m), .alu_b(alu_b_m), .alu_code(alu_code_m), .alu_c(alu_c_m), .alu_ovf(alu_ovf_m),
        .result(result_m), .done(done_m), .illegal(illegal_m), .ovf_flag(ovf_flag_m), .ovf_clr(ovf_clr)
    );

    alu_issue_ctrl #(.ALU_WAIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v_1), .instr(instr), .instr_ready(instr_ready_1),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data_1),
        .alu_a(alu_a_1), .alu_b(alu_b_1), .alu_code(alu_code_1), .alu_c(alu_c_1), .alu_ovf(alu_ovf_1),
        .result(result_1), .done(done_1), .illegal(illegal_1), .ovf_flag(ovf_flag_1), .ovf_clr(ovf_clr)
    );

    alu_issue_ctrl #(.ALU_WAIT(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .instr_valid(v_4), .instr(instr), .instr_ready(instr_ready_4),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data_4),
        .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_code(alu_code_4), .alu_c(alu_c_4), .alu_ovf(alu_ovf_4),
        .result(result_4), .done(done_4), .illegal(illegal_4), .ovf_flag(ovf_flag_4), .ovf_clr(ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic done_of(input int w);
        case (w)
            0: return done_m;
            1: return done_1;
            default: return done_4;
        endcase
    endfunction

    task automatic set_valid(input int w, input logic v);
        case (w)
            0: v_m = v;
            1: v_1 = v;
            default: v_4 = v;
        endcase
    endtask

    task automatic rd_reg(input int w, input logic [2:0] a, output logic [15:0] v);
        rd_addr = a;
        #1;
        case (w)
            0: v = rd_data_m;
            1: v = rd_data_1;
            default: v = rd_data_4;
        endcase
    endtask

    task automatic ld(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step;
        ld_en = 1'b0;
    endtask

    // Returns the number of edges until done is seen; 0 means it never came.
    task automatic wait_done(input int w, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!got) begin
                step;
                if (done_of(w)) begin
                    lat = k;
                    got = 1'b1;
                end
            end
        end
    endtask

    task automatic run_op(input int w, input logic [4:0] c, input logic [2:0] rd, input logic [2:0] rs,
                          input logic [2:0] rt, output int lat);
        instr = {c, rd, rs, rt, 2'b00};
        set_valid(w, 1'b1);
        step;
        set_valid(w, 1'b0);
        wait_done(w, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] v;
        bit          saw;

        vecs[0] = '{5'd0,  3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0005, 16'h0003, 16'h0008, 16'h0008};
        vecs[1] = '{5'd1,  3'd6, 3'd1, 3'd2, 16'h0010, 16'h0003, 16'h0010, 16'h0003, 16'h000D, 16'h000D};
        vecs[2] = '{5'd10, 3'd5, 3'd3, 3'd1, 16'h00F0, 16'h000F, 16'h00F0, 16'h000F, 16'h00FF, 16'h00FF};
        vecs[3] = '{5'd16, 3'd7, 3'd2, 3'd4, 16'hFFFF, 16'h0F0F, 16'hFFFF, 16'h0F0F, 16'hF0F0, 16'hF0F0};
        vecs[4] = '{5'd0,  3'd0, 3'd1, 3'd2, 16'h0001, 16'h0002, 16'h0001, 16'h0002, 16'h0003, 16'h0000};
        vecs[5] = '{5'd0,  3'd2, 3'd0, 3'd1, 16'h1234, 16'h0007, 16'h0000, 16'h0007, 16'h0007, 16'h0007};
        vecs[6] = '{5'd29, 3'd4, 3'd5, 3'd6, 16'h00AA, 16'h0055, 16'h00AA, 16'h0055, 16'h00FF, 16'h00FF};
        vecs[7] = '{5'd12, 3'd1, 3'd1, 3'd1, 16'h3C3C, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0000, 16'h0000};

        bad_codes[0] = 5'b00110; bad_codes[1] = 5'b00111; bad_codes[2] = 5'b01011;
        bad_codes[3] = 5'b01101; bad_codes[4] = 5'b10100; bad_codes[5] = 5'b11110;
        bad_codes[6] = 5'b11111;

        rst_n = 1'b0; instr = '0; v_m = 0; v_1 = 0; v_4 = 0;
        ld_en = 0; ld_addr = '0; ld_data = '0; rd_addr = '0; ovf_clr = 0; force_ovf = 0;

        // Reset state
        repeat (2) step;
        check("rst_ready", instr_ready_m, 1'b1);
        check("rst_alu_a", alu_a_m, 16'h0);
        check("rst_alu_code", alu_code_m, 5'h0);
        check("rst_result", result_m, 16'h0);
        check("rst_done", done_m, 1'b0);
        check("rst_ovf", ovf_flag_m, 1'b0);
        rst_n = 1'b1;
        step;
        rd_reg(0, 3'd1, v);
        check("rst_r1", v, 16'h0);

        // Table-driven legal instructions
        for (int i = 0; i < 8; i++) begin
            ld(vecs[i].rs, vecs[i].ld_s);
            ld(vecs[i].rt, vecs[i].ld_t);
            run_op(0, vecs[i].code, vecs[i].rd, vecs[i].rs, vecs[i].rt, lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_alu_a", i), alu_a_m, vecs[i].exp_a);
            check($sformatf("v%0d_alu_b", i), alu_b_m, vecs[i].exp_b);
            check($sformatf("v%0d_alu_code", i), alu_code_m, vecs[i].code);
            check($sformatf("v%0d_result", i), result_m, vecs[i].exp_res);
            check($sformatf("v%0d_ready_done", i), instr_ready_m, 1'b1);
            check($sformatf("v%0d_ovf", i), ovf_flag_m, 1'b0);
            rd_reg(0, vecs[i].rd, v);
            check($sformatf("v%0d_reg_rd", i), v, vecs[i].exp_rd);
            step;
            check($sformatf("v%0d_done_pulse", i), done_m, 1'b0);
        end

        // Illegal opcodes: ports keep values from the last legal op (0x0F0F, 0x0F0F, 01100)
        ld(3'd7, 16'h5A5A);
        for (int i = 0; i < 7; i++) begin
            instr = {bad_codes[i], 3'd7, 3'd1, 3'd2, 2'b00};
            v_m = 1'b1;
            step;
            v_m = 1'b0;
            step;
            check($sformatf("ill%0d_pulse", i), illegal_m, 1'b1);
            check($sformatf("ill%0d_ready", i), instr_ready_m, 1'b1);
            check($sformatf("ill%0d_alu_a", i), alu_a_m, 16'h0F0F);
            check($sformatf("ill%0d_alu_code", i), alu_code_m, 5'd12);
            saw = 1'b0;
            step;
            check($sformatf("ill%0d_pulse_end", i), illegal_m, 1'b0);
            for (int k = 0; k < 3; k++) begin
                if (done_m) saw = 1'b1;
                step;
            end
            check($sformatf("ill%0d_no_done", i), saw, 1'b0);
        end
        rd_reg(0, 3'd7, v);
        check("ill_reg_unchanged", v, 16'h5A5A);

        // Load offered in the same cycle as an accept is dropped
        instr = {5'b00110, 3'd0, 3'd0, 3'd0, 2'b00};
        v_m = 1'b1; ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'hBEEF;
        step;
        v_m = 1'b0; ld_en = 1'b0;
        repeat (2) step;
        rd_reg(0, 3'd7, v);
        check("ld_during_accept", v, 16'h5A5A);

        // Back-to-back: second instruction accepted in the done cycle
        ld(3'd1, 16'h0005);
        ld(3'd2, 16'h0003);
        run_op(0, 5'd0, 3'd3, 3'd1, 3'd2, lat);
        check("b2b_lat1", lat, 3);
        check("b2b_ready_in_done", instr_ready_m, 1'b1);
        instr = {5'd10, 3'd5, 3'd3, 3'd1, 2'b00};
        v_m = 1'b1;
        step;
        v_m = 1'b0;
        step;
        check("b2b_alu_a", alu_a_m, 16'h0008);
        check("b2b_alu_b", alu_b_m, 16'h0005);
        wait_done(0, lat);
        check("b2b_lat2", lat, 2);
        check("b2b_result", result_m, 16'h000D);
        rd_reg(0, 3'd5, v);
        check("b2b_r5", v, 16'h000D);

        // Overflow flag
        ld(3'd1, 16'h7FFF);
        ld(3'd2, 16'h0001);
        run_op(0, 5'd0, 3'd4, 3'd1, 3'd2, lat);
        check("ovf_result", result_m, 16'h8000);
        check("ovf_set", ovf_flag_m, 1'b1);
        ovf_clr = 1'b1;
        step;
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_flag_m, 1'b0);
        force_ovf = 1'b1;
        run_op(0, 5'd10, 3'd4, 3'd1, 3'd2, lat);
        check("ovf_or_ignored", ovf_flag_m, 1'b0);
        run_op(0, 5'd1, 3'd4, 3'd1, 3'd2, lat);
        check("ovf_sub_ignored", ovf_flag_m, 1'b0);
        run_op(0, 5'd5, 3'd4, 3'd1, 3'd2, lat);
        check("ovf_code5_set", ovf_flag_m, 1'b1);
        force_ovf = 1'b0;
        ovf_clr = 1'b1;
        run_op(0, 5'd0, 3'd4, 3'd1, 3'd2, lat);
        check("ovf_set_beats_clr", ovf_flag_m, 1'b1);
        ovf_clr = 1'b0;
        step;
        check("ovf_sticky", ovf_flag_m, 1'b1);
        ovf_clr = 1'b1;
        step;
        ovf_clr = 1'b0;
        check("ovf_clr2", ovf_flag_m, 1'b0);

        // ALU_WAIT = 1 and 4 builds
        ld(3'd1, 16'h0002);
        ld(3'd2, 16'h0003);
        ld(3'd7, 16'h1111);
        run_op(1, 5'd0, 3'd3, 3'd1, 3'd2, lat);
        check("w1_latency", lat, 2);
        check("w1_result", result_1, 16'h0005);
        instr = {5'd0, 3'd3, 3'd1, 3'd2, 2'b00};
        v_4 = 1'b1;
        step;
        v_4 = 1'b0;
        step;
        ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'h7777;
        step;
        ld_en = 1'b0;
        wait_done(2, lat);
        check("w4_latency", lat + 2, 5);
        check("w4_result", result_4, 16'h0005);
        rd_reg(2, 3'd7, v);
        check("w4_ld_in_wait", v, 16'h1111);
        rd_reg(0, 3'd7, v);
        check("main_ld_idle", v, 16'h7777);

        // Reset while the main instance is waiting on the ALU
        step;
        ld(3'd1, 16'h0009);
        ld(3'd2, 16'h0004);
        instr = {5'd1, 3'd6, 3'd1, 3'd2, 2'b00};
        v_m = 1'b1;
        step;
        v_m = 1'b0;
        step;
        check("arst_pre_alu_a", alu_a_m, 16'h0009);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", instr_ready_m, 1'b1);
        check("arst_alu_a", alu_a_m, 16'h0);
        check("arst_alu_b", alu_b_m, 16'h0);
        check("arst_alu_code", alu_code_m, 5'h0);
        check("arst_result", result_m, 16'h0);
        check("arst_ovf", ovf_flag_m, 1'b0);
        rd_reg(0, 3'd1, v);
        check("arst_r1", v, 16'h0);
        repeat (2) step;
        rst_n = 1'b1;
        saw = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step;
            if (done_m || illegal_m) saw = 1'b1;
        end
        check("arst_no_done", saw, 1'b0);
        rd_reg(0, 3'd6, v);
        check("arst_r6", v, 16'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
